// File: rtl/can_pkg.sv
// Shared CAN constants and the transmit CRC state type.
package can_pkg;

    localparam int unsigned CRC_WIDTH     = 15;
    localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;
    // Index of the last CRC field bit; the strobe that moves past it ends the shift.
    localparam logic [3:0]  CRC_BITS_LAST = 4'd14;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StShift,
        StDone
    } tcrc_state_t;

endpackage

// File: rtl/tcrc_strobe_det.sv
// Rising-edge detector for the bit-timing strobe: one fire per high phase of enable_i.
module tcrc_strobe_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    output logic fire_o
);

    logic flag_d, flag_q;

    // Flag follows enable: set while high, cleared on the first low clock.
    always_comb begin
        flag_d = enable_i;
        fire_o = enable_i & ~flag_q;
    end

    // Edge flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

endmodule

// File: rtl/tcrc_gen15.sv
// Transmit-side CAN CRC-15: accumulates per strobe, then shifts the CRC field out MSB first.
// Optional bus bit monitor during the CRC field: define TCRC_BITMON_EN.
module tcrc_gen15 #(
    parameter int unsigned          CRC_WIDTH = can_pkg::CRC_WIDTH,
    parameter logic [CRC_WIDTH-1:0] POLY      = can_pkg::CAN_CRC_POLY
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 init,
    input  logic                 data_bit,
    input  logic                 start_shift,
`ifdef TCRC_BITMON_EN
    input  logic                 bus_bit,
    output logic                 mon_err,
`endif
    output logic                 crc_bit,
    output logic [CRC_WIDTH-1:0] crc_reg,
    output logic                 busy,
    output logic                 done
);

    import can_pkg::*;

    tcrc_state_t          state_d, state_q;
    logic [CRC_WIDTH-1:0] crc_d, crc_q;
    logic [3:0]           cnt_d, cnt_q;
    logic                 fire;
`ifdef TCRC_BITMON_EN
    logic                 mon_d, mon_q;
`endif

    tcrc_strobe_det u_strobe_det (
        .clk_i    (clock),
        .rst_ni   (reset),
        .enable_i (enable),
        .fire_o   (fire)
    );

    // Next state: init beats start_shift, which beats the strobe.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
`ifdef TCRC_BITMON_EN
        mon_d   = mon_q;
`endif
        if (init) begin
            state_d = StCalc;
            crc_d   = '0;
            cnt_d   = '0;
`ifdef TCRC_BITMON_EN
            mon_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                end
                StCalc: begin
                    if (start_shift) begin
                        // Strobe in this clock is dropped; CRC is frozen for the field.
                        state_d = StShift;
                        cnt_d   = '0;
                    end else if (fire) begin
                        crc_d = {crc_q[CRC_WIDTH-2:0], 1'b0}
                              ^ ((data_bit ^ crc_q[CRC_WIDTH-1]) ? POLY : '0);
                    end
                end
                StShift: begin
                    if (fire) begin
                        crc_d = {crc_q[CRC_WIDTH-2:0], 1'b0};
                        cnt_d = cnt_q + 4'd1;
`ifdef TCRC_BITMON_EN
                        if (bus_bit != crc_q[CRC_WIDTH-1]) begin
                            mon_d = 1'b1;
                        end
`endif
                        if (cnt_q == CRC_BITS_LAST) begin
                            state_d = StDone;
                            crc_d   = '0;
                        end
                    end
                end
                StDone: begin
                    crc_d = '0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State, CRC and bit counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            crc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TCRC_BITMON_EN
    // Sticky monitor error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mon_q <= 1'b0;
        end else begin
            mon_q <= mon_d;
        end
    end

    assign mon_err = mon_q;
`endif

    assign crc_reg = crc_q;
    assign busy    = (state_q == StShift);
    assign done    = (state_q == StDone);
    assign crc_bit = busy ? crc_q[CRC_WIDTH-1] : 1'b0;

endmodule

// File: doc/tcrc_gen15.md
Name: tcrc_gen15

Overview:
- Transmit-side CAN CRC-15 unit.
- Accumulates the CRC over every stuffed-free bit the transmitter puts on the bus, one update per rising edge of the bit-strobe `enable`.
- On command, serially presents the 15 CRC bits MSB first for the CRC field.
- Sits in the transmit path next to the bit-timing/stuffing logic. It is the counterpart of the receive CRC cells.

Parameters:
- CRC_WIDTH, 15, CRC register width (CAN fixed).
- POLY, 15'h4599, generator polynomial without the x^15 term.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- enable  input  1  bit strobe from bit timing; acted on once per high phase (edge-detected).
- init  input  1  synchronous clear of CRC, counter and FSM to CALC; level, sampled each clock.
- data_bit  input  1  transmitted bit to accumulate.
- start_shift  input  1  one-clock pulse: freeze CRC and enter SHIFT.
- crc_bit  output  1  current CRC field bit (crc_reg[14]) while in SHIFT, else 0.
- crc_reg  output  15  CRC register contents.
- busy  output  1  high in SHIFT.
- done  output  1  high in DONE (all 15 bits sent).

Behaviour:
- Reset state (reset=0, asynchronous): crc_reg=0, bit counter=0, edge flag=0, FSM=IDLE. Outputs: crc_bit=0, busy=0, done=0. Reset mid-shift aborts immediately.
- Edge detection:
  - A strobe "fires" on a clock where enable=1 and edge flag=0; the edge flag then sets.
  - The flag clears on a clock where enable=0.
  - enable held high for N clocks yields exactly one action.
- FSM states: IDLE, CALC, SHIFT, DONE.
  - IDLE: init=1 -> CALC with crc_reg=0.
  - CALC, on strobe: crc_reg <= {crc_reg[13:0],1'b0} ^ (POLY if data_bit^crc_reg[14] else 0). Result is visible the clock after the strobe.
  - CALC, on start_shift: -> SHIFT, counter=0, no CRC update that clock.
  - SHIFT:
    - crc_bit=crc_reg[14] combinationally.
    - On strobe: crc_reg <= {crc_reg[13:0],1'b0} and counter+1.
    - When the strobe takes counter from 14 to 15 -> DONE.
  - DONE: crc_reg=0, crc_bit=0, done=1. Holds until init (-> CALC).
- Priority within one clock: init > start_shift > strobe.
  - init in any state clears everything and forces CALC, including during SHIFT.
  - start_shift coinciding with a strobe in CALC: the strobe is ignored (the edge flag still sets). The caller must issue start_shift between strobes.
- start_shift outside CALC is ignored. A strobe in IDLE or DONE updates only the edge flag.
- Counter width: 4 bits. It never wraps, because the exit to DONE happens at 15.

Optional Feature:
- Macro: TCRC_BITMON_EN.
- Defined:
  - Adds input bus_bit (sampled bus level) and output mon_err.
  - In SHIFT, on each strobe, if bus_bit != crc_bit then mon_err sets (sticky).
  - mon_err is cleared by init or reset.
- Undefined: no port, no logic. The CRC field is not checked against the bus.

Decomposition:
- Shared package can_pkg holds:
  - CRC_WIDTH and CAN_CRC_POLY constants.
  - tcrc_state_t enum (IDLE, CALC, SHIFT, DONE).
  - The 4-bit CRC_BITS_LAST=14 constant.
- Sub-module: tcrc_strobe_det, the enable edge detector (flag register, fire output), reused by the receive side.

Test Plan:
- Reset then init: strobe data_bit=1 -> crc_reg=15'h4599. Strobe data_bit=0 -> crc_reg=15'h4EAB.
- Hold enable high 10 clocks with data_bit=1 after init -> single update, crc_reg=15'h4599 (not iterated).
- crc_reg=15'h4599, start_shift, 15 strobes -> crc_bit sequence 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1. Then done=1, busy=0, crc_reg=0.
- init and start_shift asserted in the same clock during CALC -> CALC, crc_reg=0, busy=0.
- Assert reset after 7 shift strobes -> immediately crc_reg=0, busy=0, done=0, FSM IDLE. A later strobe without init changes nothing.
- TCRC_BITMON_EN: during the shift of 15'h4599, drive bus_bit=0 at bit 4 (expected 1) -> mon_err=1 from the next clock, stays 1 through DONE, cleared by init.
